// File: rtl/wb_joiner_if.sv
// wb_joiner_if: valid/ready stream channel with a parameterised payload width
interface wb_joiner_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  modport m (output tdata, output tvalid, input tready);
  modport s (input tdata, input tvalid, output tready);
endinterface

// File: rtl/wb_joiner.sv
// wb_joiner: pairs in-order exwb records with ALU/BRU/System results into registered writeback beats
module wb_joiner #(
  parameter int XLEN = 32,
  parameter bit ZERO_X0 = 1'b1
) (
  input logic clk,
  input logic rst,
  wb_joiner_if.s exwb_axis_if,
  wb_joiner_if.s alu_axis_if,
  wb_joiner_if.s bru_axis_if,
  wb_joiner_if.s sys_axis_if,
  wb_joiner_if.m wbrf_axis_if,
  output logic redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
  input logic invalidate
);
  typedef struct packed {
    logic sys_cmd_vld;
    logic bru_cmd_vld;
    logic alu_cmd_vld;
    logic [4:0] rd;
  } exwb_tdata_t;
  typedef struct packed {
    logic taken;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] link_data;
  } bru_result_t;
  typedef struct packed {
    logic redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] rd_data;
  } sys_result_t;
  typedef struct packed {
    logic [XLEN-1:0] wdata;
    logic [4:0] rd;
    logic we;
  } wbrf_tdata_t;
  exwb_tdata_t head;
  bru_result_t b_buf, b_cur;
  sys_result_t s_buf, s_cur;
  wbrf_tdata_t out_d;
  logic [XLEN-1:0] a_buf, a_cur;
  logic en, fire, out_v, a_v, b_v, s_v, a_use, b_use, s_use, a_hs, b_hs, s_hs;
  // A unit result is usable either from its buffer or straight off the bus (bypass).
  always_comb begin
    head = exwb_axis_if.tdata;
    en = rst && !invalidate;
    a_cur = a_v ? a_buf : alu_axis_if.tdata;
    b_cur = b_v ? b_buf : bru_axis_if.tdata;
    s_cur = s_v ? s_buf : sys_axis_if.tdata;
    fire = en && exwb_axis_if.tvalid && (!out_v || wbrf_axis_if.tready)
      && (!head.alu_cmd_vld || a_v || alu_axis_if.tvalid)
      && (!head.bru_cmd_vld || b_v || bru_axis_if.tvalid)
      && (!head.sys_cmd_vld || s_v || sys_axis_if.tvalid);
    a_use = fire && head.alu_cmd_vld;
    b_use = fire && head.bru_cmd_vld;
    s_use = fire && head.sys_cmd_vld;
    alu_axis_if.tready = en && (!a_v || a_use);
    bru_axis_if.tready = en && (!b_v || b_use);
    sys_axis_if.tready = en && (!s_v || s_use);
    a_hs = alu_axis_if.tvalid && alu_axis_if.tready;
    b_hs = bru_axis_if.tvalid && bru_axis_if.tready;
    s_hs = sys_axis_if.tvalid && sys_axis_if.tready;
    exwb_axis_if.tready = fire;
    wbrf_axis_if.tvalid = out_v;
    wbrf_axis_if.tdata = out_d;
  end
  // A captured result stays buffered unless the same cycle's fire bypassed it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a_v <= 1'b0;
      b_v <= 1'b0;
      s_v <= 1'b0;
      a_buf <= '0;
      b_buf <= '0;
      s_buf <= '0;
      out_v <= 1'b0;
      out_d <= '0;
      redirect_vld <= 1'b0;
      redirect_pc <= '0;
    end else begin
      a_v <= en && (a_hs ? !(a_use && !a_v) : a_v && !a_use);
      b_v <= en && (b_hs ? !(b_use && !b_v) : b_v && !b_use);
      s_v <= en && (s_hs ? !(s_use && !s_v) : s_v && !s_use);
      if (a_hs) a_buf <= alu_axis_if.tdata;
      if (b_hs) b_buf <= bru_axis_if.tdata;
      if (s_hs) s_buf <= sys_axis_if.tdata;
      out_v <= en && (fire || (out_v && !wbrf_axis_if.tready));
      redirect_vld <= fire && ((head.bru_cmd_vld && b_cur.taken) || (head.sys_cmd_vld && s_cur.redirect));
      if (fire) begin
        out_d.wdata <= head.sys_cmd_vld ? s_cur.rd_data : head.bru_cmd_vld ? b_cur.link_data :
          head.alu_cmd_vld ? a_cur : '0;
        out_d.rd <= head.rd;
        out_d.we <= (head.alu_cmd_vld || head.bru_cmd_vld || head.sys_cmd_vld) && !(ZERO_X0 && head.rd == 5'd0);
        redirect_pc <= head.sys_cmd_vld ? s_cur.redirect_pc : b_cur.target_pc;
      end
    end
endmodule

// File: tb/tb_wb_joiner.sv
// tb_wb_joiner: vector table, directed multi-cycle sequences and a randomized stream against a reference model
module tb_wb_joiner;
  localparam int XL = 32;
  typedef struct {
    bit fa, fb, fs;
    logic [4:0] rd;
    logic [31:0] a;
    logic [64:0] b, s;
    logic [31:0] wd;
    bit we, rv;
    logic [31:0] rpc;
  } vec_t;
  logic clk = 0, rst = 0, invalidate = 0, redirect_vld;
  logic [XL-1:0] redirect_pc;
  int total = 0, bad = 0, ncyc = 0, gap = 0, a_hs_c = 0;
  bit rdy_rand = 0, rdy_val = 1, flush = 0, hold = 0;
  logic [37:0] held;
  logic [7:0] eq[$];
  logic [31:0] aq[$];
  logic [64:0] bq[$], sq[$];
  logic [37:0] obs[$], exp_b[$];
  logic [31:0] obs_r[$], exp_r[$];
  int obs_c[$], obs_rc[$];
  vec_t v[11];
  always #5 clk = ~clk;
  wb_joiner_if #(.W(8)) exwb ();
  wb_joiner_if #(.W(XL)) alu ();
  wb_joiner_if #(.W(2*XL+1)) bru ();
  wb_joiner_if #(.W(2*XL+1)) sys ();
  wb_joiner_if #(.W(XL+6)) wbrf ();
  wb_joiner #(.XLEN(XL), .ZERO_X0(1'b1)) dut (
    .clk(clk), .rst(rst), .exwb_axis_if(exwb), .alu_axis_if(alu), .bru_axis_if(bru),
    .sys_axis_if(sys), .wbrf_axis_if(wbrf), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .invalidate(invalidate)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    obs.delete(); obs_c.delete(); obs_r.delete(); obs_rc.delete(); exp_b.delete(); exp_r.delete();
  endtask
  task automatic wait_n(input string nm, input int n, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk({nm, " beats arrived"}, obs.size() >= n, 1);
  endtask
  function automatic vec_t mk(bit fa, bit fb, bit fs, logic [4:0] rd, logic [31:0] a, logic [64:0] b,
                              logic [64:0] s, logic [31:0] wd, bit we, bit rv, logic [31:0] rpc);
    vec_t t;
    t.fa = fa; t.fb = fb; t.fs = fs; t.rd = rd; t.a = a; t.b = b; t.s = s;
    t.wd = wd; t.we = we; t.rv = rv; t.rpc = rpc;
    return t;
  endfunction
  // Reference model: joins straight from the writeback rules, one record at a time.
  task automatic gen(input int n);
    logic [2:0] f;
    logic [4:0] rd;
    logic [31:0] a, wd;
    logic [64:0] b, s;
    for (int i = 0; i < n; i++) begin
      f = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      a = $urandom;
      b = {($urandom_range(0, 3) == 0), $urandom, $urandom};
      s = {($urandom_range(0, 7) == 0), $urandom, $urandom};
      eq.push_back({f, rd});
      if (f[0]) aq.push_back(a);
      if (f[1]) bq.push_back(b);
      if (f[2]) sq.push_back(s);
      wd = f[2] ? s[31:0] : f[1] ? b[31:0] : f[0] ? a : 32'h0;
      exp_b.push_back({wd, rd, (f != 3'b0) && (rd != 5'd0)});
      if ((f[1] && b[64]) || (f[2] && s[64])) exp_r.push_back(f[2] ? s[63:32] : b[63:32]);
    end
  endtask
  // Stream drivers and output monitor: sample at negedge, drive 1 time unit after posedge.
  initial begin
    logic he, ha, hb, hs;
    exwb.tvalid = 0; exwb.tdata = '0; alu.tvalid = 0; alu.tdata = '0;
    bru.tvalid = 0; bru.tdata = '0; sys.tvalid = 0; sys.tdata = '0; wbrf.tready = 1;
    forever begin
      @(negedge clk);
      ncyc++;
      he = exwb.tvalid && exwb.tready;
      ha = alu.tvalid && alu.tready;
      hb = bru.tvalid && bru.tready;
      hs = sys.tvalid && sys.tready;
      if (ha) a_hs_c = ncyc;
      if (wbrf.tvalid && wbrf.tready) begin obs.push_back(wbrf.tdata); obs_c.push_back(ncyc); end
      if (redirect_vld) begin obs_r.push_back(redirect_pc); obs_rc.push_back(ncyc); end
      if (hold && rst) chk("held beat stable", {wbrf.tvalid, wbrf.tdata}, {1'b1, held});
      hold = wbrf.tvalid && !wbrf.tready && rst && !invalidate;
      held = wbrf.tdata;
      @(posedge clk);
      #1;
      if (flush) begin
        eq.delete(); aq.delete(); bq.delete(); sq.delete();
        exwb.tvalid = 0; alu.tvalid = 0; bru.tvalid = 0; sys.tvalid = 0;
      end else begin
        if (he) begin void'(eq.pop_front()); exwb.tvalid = 0; end
        if (ha) begin void'(aq.pop_front()); alu.tvalid = 0; end
        if (hb) begin void'(bq.pop_front()); bru.tvalid = 0; end
        if (hs) begin void'(sq.pop_front()); sys.tvalid = 0; end
      end
      if (!exwb.tvalid && eq.size() > 0 && $urandom_range(0, 99) >= gap) begin exwb.tdata = eq[0]; exwb.tvalid = 1; end
      if (!alu.tvalid && aq.size() > 0 && $urandom_range(0, 99) >= gap) begin alu.tdata = aq[0]; alu.tvalid = 1; end
      if (!bru.tvalid && bq.size() > 0 && $urandom_range(0, 99) >= gap) begin bru.tdata = bq[0]; bru.tvalid = 1; end
      if (!sys.tvalid && sq.size() > 0 && $urandom_range(0, 99) >= gap) begin sys.tdata = sq[0]; sys.tvalid = 1; end
      wbrf.tready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end
  initial begin
    v[0] = mk(1, 0, 0, 5, 32'hAA, '0, '0, 32'hAA, 1, 0, 0);
    v[1] = mk(0, 1, 0, 1, 0, {1'b1, 32'h8000_0100, 32'h8000_0004}, '0, 32'h8000_0004, 1, 1, 32'h8000_0100);
    v[2] = mk(1, 0, 0, 0, 32'h1234, '0, '0, 32'h1234, 0, 0, 0);
    v[3] = mk(0, 0, 0, 0, 0, '0, '0, 32'h0, 0, 0, 0);
    v[4] = mk(0, 0, 0, 9, 0, '0, '0, 32'h0, 0, 0, 0);
    v[5] = mk(0, 1, 0, 0, 0, {1'b0, 32'h8000_0200, 32'h8000_0008}, '0, 32'h8000_0008, 0, 0, 0);
    v[6] = mk(0, 0, 1, 0, 0, '0, {1'b1, 32'h100, 32'h0}, 32'h0, 0, 1, 32'h100);
    v[7] = mk(1, 0, 1, 3, 32'h66, '0, {1'b0, 32'h0, 32'h55}, 32'h55, 1, 0, 0);
    v[8] = mk(1, 1, 0, 2, 32'h11, {1'b1, 32'h8000_0040, 32'h8000_0030}, '0, 32'h8000_0030, 1, 1, 32'h8000_0040);
    v[9] = mk(0, 1, 1, 7, 0, {1'b1, 32'h8000_0400, 32'h8000_0404}, {1'b0, 32'h200, 32'hABCD}, 32'hABCD, 1, 1, 32'h200);
    v[10] = mk(0, 0, 1, 4, 0, '0, {1'b1, 32'h300, 32'hC0DE}, 32'hC0DE, 1, 1, 32'h300);
    repeat (2) cyc();
    chk("reset wbrf tvalid", wbrf.tvalid, 0);
    chk("reset wbrf tdata", wbrf.tdata, 0);
    chk("reset redirect", {redirect_vld, redirect_pc}, 0);
    chk("reset slave treadys", {exwb.tready, alu.tready, bru.tready, sys.tready}, 0);
    rst = 1;
    cyc();
    for (int i = 0; i < 11; i++) begin
      clr();
      eq.push_back({v[i].fs, v[i].fb, v[i].fa, v[i].rd});
      if (v[i].fa) aq.push_back(v[i].a);
      if (v[i].fb) bq.push_back(v[i].b);
      if (v[i].fs) sq.push_back(v[i].s);
      wait_n($sformatf("vec%0d", i), 1, 20);
      repeat (3) cyc();
      chk($sformatf("vec%0d beat", i), obs.size() > 0 ? obs[0] : 'x, {v[i].wd, v[i].rd, v[i].we});
      chk($sformatf("vec%0d beat count", i), obs.size(), 1);
      chk($sformatf("vec%0d redirect count", i), obs_r.size(), v[i].rv);
      if (v[i].rv && obs_r.size() > 0) begin
        chk($sformatf("vec%0d redirect pc", i), obs_r[0], v[i].rpc);
        chk($sformatf("vec%0d redirect with beat", i), obs_rc[0], obs_c[0]);
      end
    end
    clr();
    eq.push_back({3'b001, 5'd5});
    repeat (4) cyc();
    chk("late alu no early beat", {wbrf.tvalid, exwb.tready}, 0);
    aq.push_back(32'hAA);
    wait_n("late alu", 1, 10);
    repeat (2) cyc();
    chk("late alu beat", obs.size() > 0 ? obs[0] : 'x, {32'hAA, 5'd5, 1'b1});
    chk("late alu latency", obs.size() > 0 ? obs_c[0] - a_hs_c : -1, 1);
    chk("late alu no redirect", obs_r.size(), 0);
    clr();
    rdy_val = 0;
    for (int i = 0; i < 3; i++) begin
      eq.push_back({3'b001, 5'(10 + i)});
      aq.push_back(32'h100 + i);
    end
    repeat (6) cyc();
    @(negedge clk);
    chk("bp no handshake", obs.size(), 0);
    chk("bp held beat", {wbrf.tvalid, wbrf.tdata}, {1'b1, 32'h100, 5'd10, 1'b1});
    chk("bp alu stalled", {alu.tvalid, alu.tready, exwb.tready}, 3'b100);
    rdy_val = 1;
    wait_n("bp release", 3, 20);
    repeat (3) cyc();
    chk("bp beat count", obs.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("bp beat%0d", i), i < obs.size() ? obs[i] : 'x, {32'h100 + i, 5'(10 + i), 1'b1});
    chk("bp back to back", obs.size() == 3 ? obs_c[2] - obs_c[0] : -1, 2);
    clr();
    eq.push_back({3'b010, 5'd4});
    eq.push_back({3'b001, 5'd6});
    aq.push_back(32'h77);
    repeat (4) cyc();
    @(negedge clk);
    chk("young alu waits", obs.size(), 0);
    chk("young alu buffered", {alu.tvalid, alu.tready, exwb.tready}, 0);
    bq.push_back({1'b0, 32'h8000_0100, 32'h8000_0010});
    wait_n("young alu", 2, 10);
    chk("order beat0", obs.size() > 0 ? obs[0] : 'x, {32'h8000_0010, 5'd4, 1'b1});
    chk("order beat1", obs.size() > 1 ? obs[1] : 'x, {32'h77, 5'd6, 1'b1});
    chk("order consecutive", obs.size() > 1 ? obs_c[1] - obs_c[0] : -1, 1);
    clr();
    rdy_val = 0;
    eq.push_back({3'b001, 5'd8}); aq.push_back(32'h1);
    eq.push_back({3'b001, 5'd9}); aq.push_back(32'h2);
    bq.push_back({1'b1, 32'h40, 32'h44});
    repeat (6) cyc();
    @(negedge clk);
    chk("inv pending", {wbrf.tvalid, alu.tready, bru.tready}, 3'b100);
    cyc();
    invalidate = 1;
    flush = 1;
    cyc();
    invalidate = 0;
    cyc();
    flush = 0;
    @(negedge clk);
    chk("inv dropped beat", {wbrf.tvalid, redirect_vld}, 0);
    chk("inv buffers empty", {alu.tready, bru.tready, sys.tready}, 3'b111);
    chk("inv no handshake", obs.size(), 0);
    rdy_val = 1;
    cyc();
    clr();
    gap = 40;
    rdy_rand = 1;
    gen(200);
    wait_n("random", 200, 5000);
    repeat (5) cyc();
    chk("random beat count", obs.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) chk($sformatf("random beat%0d", i), i < obs.size() ? obs[i] : 'x, exp_b[i]);
    chk("random redirect count", obs_r.size(), exp_r.size());
    for (int i = 0; i < exp_r.size(); i++) chk($sformatf("random redirect%0d", i), i < obs_r.size() ? obs_r[i] : 'x, exp_r[i]);
    clr();
    gen(20);
    repeat (8) cyc();
    #2;
    rst = 0;
    #1;
    chk("midreset wbrf", {wbrf.tvalid, wbrf.tdata}, 0);
    chk("midreset redirect", {redirect_vld, redirect_pc}, 0);
    chk("midreset treadys", {exwb.tready, alu.tready, bru.tready, sys.tready}, 0);
    flush = 1;
    repeat (2) cyc();
    flush = 0;
    rst = 1;
    cyc();
    chk("after reset idle", {wbrf.tvalid, redirect_vld}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
